// File: rtl/mac_seq_ctrl.sv
// Sequencer for C = A x B over externally stored matrices: walks i/j/k, accumulates
// signed products in a full-width accumulator and strobes each finished element out.
module mac_seq_ctrl #(
    parameter int M                        = 4,
    parameter int K                        = 4,
    parameter int N                        = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K),
    parameter int ADDR_WIDTH_M             = $clog2(M),
    parameter int ADDR_WIDTH_K             = $clog2(K),
    parameter int ADDR_WIDTH_N             = $clog2(N)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                stop,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
    output logic [ADDR_WIDTH_M-1:0]             row_addr_a,
    output logic [ADDR_WIDTH_K-1:0]             col_addr_a,
    output logic [ADDR_WIDTH_K-1:0]             row_addr_b,
    output logic [ADDR_WIDTH_N-1:0]             col_addr_b,
    output logic [ADDR_WIDTH_M-1:0]             row_addr_c,
    output logic [ADDR_WIDTH_N-1:0]             col_addr_c,
    output logic                                matrix_a_re,
    output logic                                matrix_b_re,
    output logic                                matrix_c_we,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
    output logic                                busy,
    output logic                                done,
    output logic                                aborted
);

    localparam int PW = 2 * DATA_WIDTH_INIT_MATRIX;
    localparam int AW = DATA_WIDTH_RESULT_MATRIX;
    localparam logic [ADDR_WIDTH_M-1:0] I_LAST = ADDR_WIDTH_M'(M - 1);
    localparam logic [ADDR_WIDTH_K-1:0] K_LAST = ADDR_WIDTH_K'(K - 1);
    localparam logic [ADDR_WIDTH_N-1:0] J_LAST = ADDR_WIDTH_N'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_r, state_nxt_s;
    logic [ADDR_WIDTH_M-1:0]  i_r, i_nxt_s;
    logic [ADDR_WIDTH_K-1:0]  k_r, k_nxt_s;
    logic [ADDR_WIDTH_N-1:0]  j_r, j_nxt_s;
    logic signed [AW-1:0]     acc_r, acc_nxt_s;
    logic signed [PW-1:0]     prod_s;
    logic                     done_nxt_s, aborted_nxt_s, busy_nxt_s;
    logic                     re_nxt_s, we_nxt_s, we_r;
    logic [ADDR_WIDTH_M-1:0]  row_a_nxt_s, row_c_nxt_s;
    logic [ADDR_WIDTH_K-1:0]  col_a_nxt_s, row_b_nxt_s;
    logic [ADDR_WIDTH_N-1:0]  col_b_nxt_s, col_c_nxt_s;
    logic [AW-1:0]            data_c_nxt_s;

    // Full-width signed product of the current A and B elements
    always_comb begin
        prod_s = PW'($signed(data_out_a)) * PW'($signed(data_out_b));
    end

    // Next-state, loop index and accumulator logic
    always_comb begin
        state_nxt_s   = state_r;
        i_nxt_s       = i_r;
        j_nxt_s       = j_r;
        k_nxt_s       = k_r;
        acc_nxt_s     = acc_r;
        done_nxt_s    = 1'b0;
        aborted_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = MAC;
                    i_nxt_s     = '0;
                    j_nxt_s     = '0;
                    k_nxt_s     = '0;
                    acc_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MAC: begin
                if (stop) begin
                    state_nxt_s   = IDLE;
                    aborted_nxt_s = 1'b1;
                    i_nxt_s       = '0;
                    j_nxt_s       = '0;
                    k_nxt_s       = '0;
                    acc_nxt_s     = '0;
                end else begin
                    // Accumulator is wide enough for K products, so no saturation
                    acc_nxt_s = acc_r + AW'(prod_s);
                    if (k_r == K_LAST) begin
                        k_nxt_s     = '0;
                        state_nxt_s = WRITE;
                    end else begin
                        k_nxt_s = k_r + ADDR_WIDTH_K'(1);
                    end
                end
            end
            WRITE: begin
                acc_nxt_s = '0;
                if (stop) begin
                    state_nxt_s   = IDLE;
                    aborted_nxt_s = 1'b1;
                    i_nxt_s       = '0;
                    j_nxt_s       = '0;
                    k_nxt_s       = '0;
                end else if (j_r == J_LAST) begin
                    j_nxt_s = '0;
                    if (i_r == I_LAST) begin
                        i_nxt_s     = '0;
                        state_nxt_s = DONE;
                    end else begin
                        i_nxt_s     = i_r + ADDR_WIDTH_M'(1);
                        state_nxt_s = MAC;
                    end
                end else begin
                    j_nxt_s     = j_r + ADDR_WIDTH_N'(1);
                    state_nxt_s = MAC;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                done_nxt_s  = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so outputs come straight from flops
    always_comb begin
        row_a_nxt_s  = '0;
        col_a_nxt_s  = '0;
        row_b_nxt_s  = '0;
        col_b_nxt_s  = '0;
        row_c_nxt_s  = '0;
        col_c_nxt_s  = '0;
        re_nxt_s     = 1'b0;
        we_nxt_s     = 1'b0;
        busy_nxt_s   = 1'b0;
        data_c_nxt_s = '0;
        case (state_nxt_s)
            MAC: begin
                row_a_nxt_s = i_nxt_s;
                col_a_nxt_s = k_nxt_s;
                row_b_nxt_s = k_nxt_s;
                col_b_nxt_s = j_nxt_s;
                re_nxt_s    = 1'b1;
                busy_nxt_s  = 1'b1;
            end
            WRITE: begin
                row_c_nxt_s  = i_nxt_s;
                col_c_nxt_s  = j_nxt_s;
                we_nxt_s     = 1'b1;
                busy_nxt_s   = 1'b1;
                data_c_nxt_s = acc_nxt_s;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // State, index, accumulator and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            i_r         <= '0;
            j_r         <= '0;
            k_r         <= '0;
            acc_r       <= '0;
            row_addr_a  <= '0;
            col_addr_a  <= '0;
            row_addr_b  <= '0;
            col_addr_b  <= '0;
            row_addr_c  <= '0;
            col_addr_c  <= '0;
            matrix_a_re <= 1'b0;
            matrix_b_re <= 1'b0;
            we_r        <= 1'b0;
            data_in_c   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            i_r         <= i_nxt_s;
            j_r         <= j_nxt_s;
            k_r         <= k_nxt_s;
            acc_r       <= acc_nxt_s;
            row_addr_a  <= row_a_nxt_s;
            col_addr_a  <= col_a_nxt_s;
            row_addr_b  <= row_b_nxt_s;
            col_addr_b  <= col_b_nxt_s;
            row_addr_c  <= row_c_nxt_s;
            col_addr_c  <= col_c_nxt_s;
            matrix_a_re <= re_nxt_s;
            matrix_b_re <= re_nxt_s;
            we_r        <= we_nxt_s;
            data_in_c   <= data_c_nxt_s;
            busy        <= busy_nxt_s;
            done        <= done_nxt_s;
            aborted     <= aborted_nxt_s;
        end
    end

    // A stop in the WRITE cycle must suppress the strobe in that same cycle
    assign matrix_c_we = we_r & ~stop;

endmodule
